// File: rtl/mem_march_master.sv
// Four-phase march-test initiator for the single-port test memory.
// Writes P ascending, reads P ascending, writes ~P descending, reads ~P descending.
module mem_march_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
);

  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, W0, R0, D0, W1, R1, D1, FIN} state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [DATA_WIDTH-1:0] pat, pat_d;
  logic                  busy_d, done_d, pass_d;
  logic [15:0]           err_d;
  logic [ADDR_WIDTH-1:0] fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_exp_d, fail_act_d;
  logic                  first_seen, first_seen_d;
  logic                  mem_en_d, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  // One-stage compare pipeline: the read on the bus this cycle is checked next cycle
  logic                  cmp_vld, cmp_vld_d;
  logic [DATA_WIDTH-1:0] cmp_exp, cmp_exp_d;
  logic [CNT_W-1:0]      cmp_addr, cmp_addr_d;
  logic                  mismatch_c;

  assign mismatch_c = cmp_vld && (!mem_valid || (mem_rdata != cmp_exp));

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    pat_d        = pat;
    busy_d       = busy;
    done_d       = 1'b0;
    pass_d       = pass;
    err_d        = err_count;
    fail_addr_d  = fail_addr;
    fail_exp_d   = fail_exp;
    fail_act_d   = fail_act;
    first_seen_d = first_seen;
    mem_en_d     = mem_en;
    mem_wr_d     = mem_wr;
    mem_wdata_d  = mem_wdata;
    cmp_vld_d    = 1'b0;
    cmp_exp_d    = cmp_exp;
    cmp_addr_d   = cmp_addr;

    if (mismatch_c) begin
      if (err_count != ERR_MAX) err_d = err_count + 16'd1;
      if (!first_seen) begin
        first_seen_d = 1'b1;
        fail_addr_d  = ADDR_WIDTH'(cmp_addr);
        fail_exp_d   = cmp_exp;
        fail_act_d   = mem_rdata;
      end
    end

    case (state)
      IDLE: begin
        mem_en_d = 1'b0;
        if (start) begin
          pat_d        = pattern;
          err_d        = '0;
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_exp_d   = '0;
          fail_act_d   = '0;
          first_seen_d = 1'b0;
          cnt_d        = '0;
          busy_d       = 1'b1;
          mem_en_d     = 1'b1;
          mem_wr_d     = 1'b1;
          mem_wdata_d  = pattern;
          state_d      = W0;
        end
      end
      W0: begin
        if (cnt == LAST_ADDR) begin
          cnt_d    = '0;
          mem_wr_d = 1'b0;
          state_d  = R0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      R0: begin
        cmp_vld_d  = 1'b1;
        cmp_exp_d  = pat;
        cmp_addr_d = cnt;
        if (cnt == LAST_ADDR) begin
          mem_en_d = 1'b0;
          state_d  = D0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      D0: begin
        cnt_d       = LAST_ADDR;
        mem_en_d    = 1'b1;
        mem_wr_d    = 1'b1;
        mem_wdata_d = ~pat;
        state_d     = W1;
      end
      W1: begin
        if (cnt == '0) begin
          cnt_d    = LAST_ADDR;
          mem_wr_d = 1'b0;
          state_d  = R1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      R1: begin
        cmp_vld_d  = 1'b1;
        cmp_exp_d  = ~pat;
        cmp_addr_d = cnt;
        if (cnt == '0) begin
          mem_en_d = 1'b0;
          state_d  = D1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      D1: begin
        // The last R1 compare lands on this edge, so pass uses the updated count
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
        state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_addr_d = ADDR_WIDTH'(cnt_d);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pat        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
      first_seen <= 1'b0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cmp_vld    <= 1'b0;
      cmp_exp    <= '0;
      cmp_addr   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pat        <= pat_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_count  <= err_d;
      fail_addr  <= fail_addr_d;
      fail_exp   <= fail_exp_d;
      fail_act   <= fail_act_d;
      first_seen <= first_seen_d;
      mem_en     <= mem_en_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cmp_vld    <= cmp_vld_d;
      cmp_exp    <= cmp_exp_d;
      cmp_addr   <= cmp_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_march_master.sv
// Bench for mem_march_master: faulty memory model, queued expected bus beats and results.
module tb_mem_march_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned RUN_CYC = 4 * DEPTH + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_act;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;

  always #5 clk = ~clk;

  mem_march_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } bus_t;

  typedef struct packed {
    logic [15:0]   err;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
    logic [DW-1:0] act;
    logic          pass;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory with injectable faults: stuck bits on write, inverted reads, one dropped valid
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sa0 [DEPTH];
  logic [DW-1:0] sa1 [DEPTH];
  logic          inv = 1'b0;
  int            kill_idx = -1;
  int            rd_idx = 0;

  always @(posedge clk) begin
    if (!busy) rd_idx <= 0;
    if (mem_en) begin
      if (mem_wr) begin
        mem[mem_addr[3:0]] <= (mem_wdata & ~sa0[mem_addr[3:0]]) | sa1[mem_addr[3:0]];
        mem_valid <= 1'b0;
      end else begin
        mem_rdata <= inv ? ~mem[mem_addr[3:0]] : mem[mem_addr[3:0]];
        mem_valid <= (rd_idx != kill_idx);
        rd_idx    <= rd_idx + 1;
      end
    end
  end

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      sa0[a] = '0;
      sa1[a] = '0;
    end
    inv = 1'b0;
    kill_idx = -1;
  endtask

  // Reference: walk the 2*DEPTH reads of a run and apply the fault rules directly
  function automatic res_t model(input logic [DW-1:0] p);
    res_t r;
    bit   first;
    r = '0;
    first = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      int            a;
      logic [DW-1:0] e, act;
      if (i < DEPTH) begin a = i; e = p; end
      else begin a = 2 * DEPTH - 1 - i; e = ~p; end
      act = (e & ~sa0[a]) | sa1[a];
      if (inv) act = ~act;
      if (i == kill_idx || act != e) begin
        if (r.err != 16'hFFFF) r.err = r.err + 16'd1;
        if (!first) begin
          first  = 1;
          r.addr = AW'(a);
          r.exp  = e;
          r.act  = act;
        end
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic push_bus(input logic [DW-1:0] p);
    for (int a = 0; a < DEPTH; a++) bus_q.push_back({1'b1, AW'(a), p});
    for (int a = 0; a < DEPTH; a++) bus_q.push_back({1'b0, AW'(a), {DW{1'b0}}});
    for (int a = DEPTH - 1; a >= 0; a--) bus_q.push_back({1'b1, AW'(a), ~p});
    for (int a = DEPTH - 1; a >= 0; a--) bus_q.push_back({1'b0, AW'(a), {DW{1'b0}}});
  endtask

  // Monitor: every enabled bus cycle and every done pulse pops an expectation
  int busy_cnt = 0;
  always @(negedge clk) begin
    bus_t b;
    res_t r;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_en) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_access", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          b = bus_q.pop_front();
          chk("bus_wr", 64'(mem_wr), 64'(b.wr));
          chk("bus_addr", 64'(mem_addr), 64'(b.addr));
          if (b.wr) chk("bus_wdata", 64'(mem_wdata), 64'(b.data));
        end
      end
      if (done) begin
        chk("busy_cycles", 64'(busy_cnt), 64'(RUN_CYC));
        chk("busy_low_at_done", 64'(busy), 64'd0);
        busy_cnt = 0;
        if (res_q.size() == 0) begin
          chk("done_unexpected", 64'd1, 64'd0);
        end else begin
          r = res_q.pop_front();
          chk("err_count", 64'(err_count), 64'(r.err));
          chk("fail_addr", 64'(fail_addr), 64'(r.addr));
          chk("fail_exp", 64'(fail_exp), 64'(r.exp));
          chk("fail_act", 64'(fail_act), 64'(r.act));
          chk("pass", 64'(pass), 64'(r.pass));
        end
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_fail_addr", 64'(fail_addr), 64'd0);
    chk("rst_fail_exp", 64'(fail_exp), 64'd0);
    chk("rst_fail_act", 64'(fail_act), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy || done) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue_start(input logic [DW-1:0] p);
    @(negedge clk);
    start   = 1'b1;
    pattern = p;
    res_q.push_back(model(p));
    push_bus(p);
    @(negedge clk);
    start   = 1'b0;
    pattern = DW'($urandom);
  endtask

  task automatic run(input logic [DW-1:0] p, input bit mid_start);
    int t = 0;
    wait_idle();
    issue_start(p);
    if (mid_start) begin
      repeat (9) @(negedge clk);
      start = 1'b1;
      pattern = DW'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    clear_faults();
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Clean run, then stuck-at-0 bit 0 at addr 5
    run(32'hA5A5A5A5, 1'b0);
    sa0[5] = 32'h0000_0001;
    run(32'hA5A5A5A5, 1'b0);
    clear_faults();

    // Ignored mid-run start; this clean run also shows the error state cleared
    run(32'hA5A5A5A5, 1'b1);

    // Dropped valid on the compare of R1 addr 0 (last read of the run)
    kill_idx = 2 * DEPTH - 1;
    run(32'hA5A5A5A5, 1'b0);
    clear_faults();

    // Every read returns the inverse of what was written
    inv = 1'b1;
    run(32'h0F0F_1234, 1'b0);
    clear_faults();

    // Randomized patterns and fault mixes
    for (int k = 0; k < 10; k++) begin
      int mode = $urandom_range(0, 3);
      clear_faults();
      if (mode == 1) sa0[$urandom_range(0, DEPTH - 1)] = DW'(1) << $urandom_range(0, DW - 1);
      if (mode == 2) sa1[$urandom_range(0, DEPTH - 1)] = DW'(1) << $urandom_range(0, DW - 1);
      if (mode == 3) kill_idx = $urandom_range(0, 2 * DEPTH - 1);
      if ($urandom_range(0, 3) == 0) sa0[$urandom_range(0, DEPTH - 1)] = DW'($urandom);
      run(DW'($urandom), 1'b0);
    end
    clear_faults();

    // Asynchronous reset in the middle of R0
    wait_idle();
    issue_start(32'h1357_9BDF);
    repeat (20) @(negedge clk);
    chk("in_r0_read", 64'({mem_en, mem_wr}), 64'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    bus_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_quiet_en", 64'(mem_en), 64'd0);
    chk("post_reset_quiet_busy", 64'(busy), 64'd0);

    // Run after reset still works
    run(32'hFFFF_0000, 1'b0);
    repeat (4) @(negedge clk);
    chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
    chk("res_q_drained", 64'(res_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
